// File: rtl/mac_tx_pkt_gen_if.sv
// Avalon-ST TX client bundle between the packet generator and the MAC.
// Master drives beats; slave returns tx_ready (readyLatency 0).
interface mac_tx_pkt_gen_if #(
  parameter int DATA_W  = 64,
  parameter int EMPTY_W = 3
);
  logic               tx_valid;
  logic               tx_ready;
  logic               tx_startofpacket;
  logic               tx_endofpacket;
  logic [DATA_W-1:0]  tx_data;
  logic [EMPTY_W-1:0] tx_empty;
  logic               tx_error;

  modport master (
    output tx_valid,
    output tx_startofpacket,
    output tx_endofpacket,
    output tx_data,
    output tx_empty,
    output tx_error,
    input  tx_ready
  );

  modport slave (
    input  tx_valid,
    input  tx_startofpacket,
    input  tx_endofpacket,
    input  tx_data,
    input  tx_empty,
    input  tx_error,
    output tx_ready
  );
endinterface

// File: rtl/mac_tx_pkt_gen.sv
// Ethernet frame generator for the MAC TX client (no FCS).
// Sequence-numbered payload, backpressure aware, programmable IPG.
module mac_tx_pkt_gen #(
  parameter int          DATA_W    = 64,
  parameter int          EMPTY_W   = 3,
  parameter int          MIN_LEN   = 60,
  parameter int          MAX_LEN   = 1514,
  parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
  input  logic        clock156,
  input  logic        rst156,
  input  logic        start,
  input  logic        stop,
  input  logic [31:0] cfg_pkt_count,
  input  logic [13:0] cfg_pkt_len,
  input  logic [7:0]  cfg_ipg,
  input  logic [47:0] cfg_dst_mac,
  input  logic [47:0] cfg_src_mac,
  mac_tx_pkt_gen_if.master tx,
  output logic        busy,
  output logic        done,
  output logic [31:0] sent_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_IPG
  } state_t;

  localparam logic [13:0] MIN_L = 14'(MIN_LEN);
  localparam logic [13:0] MAX_L = 14'(MAX_LEN);

  state_t              r_state;
  logic                r_valid;
  logic                r_sop;
  logic                r_eop;
  logic [DATA_W-1:0]   r_data;
  logic [EMPTY_W-1:0]  r_empty;
  logic                r_busy;
  logic                r_done;
  logic [31:0]         r_sent;
  logic [31:0]         r_seq;
  logic [7:0]          r_idx;
  logic [7:0]          r_ipg_cnt;
  logic [13:0]         r_len;
  logic [7:0]          r_beats;
  logic [31:0]         r_pkt_cnt;
  logic [7:0]          r_ipg;
  logic [47:0]         r_dst;
  logic [47:0]         r_src;

  logic                w_xfer;
  logic                w_end;
  logic                w_load;
  logic [13:0]         w_len_c;
  logic [7:0]          w_nxt_idx;
  logic [31:0]         w_nxt_seq;
  logic [143:0]        w_hdr;
  logic [DATA_W-1:0]   w_data;
  logic                w_last;
  logic [EMPTY_W-1:0]  w_empty;

  // Header bytes 0..17 live in w_hdr; payload byte k is simply k[7:0].
  function automatic logic [7:0] byte_at(
    input logic [13:0]  k,
    input logic [13:0]  len,
    input logic [143:0] hdr
  );
    if (k >= len)
      byte_at = 8'h00;
    else if (k < 14'd18)
      byte_at = 8'(hdr >> {5'(5'd17 - k[4:0]), 3'b000});
    else
      byte_at = k[7:0];
  endfunction

  assign w_len_c = (cfg_pkt_len < MIN_L) ? MIN_L :
                   (cfg_pkt_len > MAX_L) ? MAX_L : cfg_pkt_len;

  assign w_xfer = r_valid & tx.tx_ready;
  assign w_end  = stop ||
                  (r_pkt_cnt != 32'd0 && r_sent + 32'd1 == r_pkt_cnt);

  assign w_nxt_idx = (r_state == S_SEND && r_valid && !r_eop) ?
                     r_idx + 8'd1 : 8'd0;
  assign w_nxt_seq = (r_state == S_SEND && r_valid && r_eop) ?
                     r_seq + 32'd1 : r_seq;
  assign w_hdr     = {r_dst, r_src, ETHERTYPE, w_nxt_seq};
  assign w_last    = (w_nxt_idx == r_beats - 8'd1);
  assign w_empty   = w_last ?
                     EMPTY_W'(4'd8 - {1'b0, r_len[2:0]}) : '0;

  always_comb begin
    w_data = '0;
    for (int j = 0; j < 8; j++)
      w_data[63-8*j -: 8] = byte_at(
        {3'b000, w_nxt_idx, 3'b000} + 14'(j), r_len, w_hdr);
  end

  always_comb begin
    w_load = 1'b0;
    unique case (r_state)
      S_SEND:
        w_load = !r_valid ||
                 (w_xfer && (!r_eop || (!w_end && r_ipg == 8'd0)));
      S_IPG:
        w_load = !stop && r_ipg_cnt == 8'd0;
      default:
        w_load = 1'b0;
    endcase
  end

  always_ff @(posedge clock156) begin
    if (rst156) begin
      r_state   <= S_IDLE;
      r_valid   <= 1'b0;
      r_sop     <= 1'b0;
      r_eop     <= 1'b0;
      r_data    <= '0;
      r_empty   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_sent    <= '0;
      r_seq     <= '0;
      r_idx     <= '0;
      r_ipg_cnt <= '0;
      r_len     <= '0;
      r_beats   <= '0;
      r_pkt_cnt <= '0;
      r_ipg     <= '0;
      r_dst     <= '0;
      r_src     <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start && !stop) begin
            r_len     <= w_len_c;
            r_beats   <= 8'((w_len_c + 14'd7) >> 3);
            r_pkt_cnt <= cfg_pkt_count;
            r_ipg     <= cfg_ipg;
            r_dst     <= cfg_dst_mac;
            r_src     <= cfg_src_mac;
            r_sent    <= '0;
            r_seq     <= '0;
            r_busy    <= 1'b1;
            r_state   <= S_SEND;
          end
        end
        S_SEND: begin
          if (w_xfer && r_eop) begin
            r_sent <= r_sent + 32'd1;
            r_seq  <= r_seq + 32'd1;
            if (w_end) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else if (r_ipg != 8'd0) begin
              r_state   <= S_IPG;
              r_ipg_cnt <= r_ipg - 8'd1;
            end
            if (w_end || r_ipg != 8'd0) begin
              r_valid <= 1'b0;
              r_sop   <= 1'b0;
              r_eop   <= 1'b0;
              r_data  <= '0;
              r_empty <= '0;
            end
          end
        end
        S_IPG: begin
          if (stop) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (r_ipg_cnt != 8'd0) begin
            r_ipg_cnt <= r_ipg_cnt - 8'd1;
          end else begin
            r_state <= S_SEND;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_load) begin
        r_valid <= 1'b1;
        r_sop   <= (w_nxt_idx == 8'd0);
        r_eop   <= w_last;
        r_data  <= w_data;
        r_empty <= w_empty;
        r_idx   <= w_nxt_idx;
      end
    end
  end

  assign tx.tx_valid         = r_valid;
  assign tx.tx_startofpacket = r_sop;
  assign tx.tx_endofpacket   = r_eop;
  assign tx.tx_data          = r_data;
  assign tx.tx_empty         = r_empty;
  assign tx.tx_error         = 1'b0;
  assign busy                = r_busy;
  assign done                = r_done;
  assign sent_count          = r_sent;

endmodule

// File: doc/mac_tx_pkt_gen.md
Name: mac_tx_pkt_gen

Overview:
Avalon-ST traffic generator that feeds the 64-bit TX client interface of a MacPhy instance (bench side of the MAC loopback). It produces configurable Ethernet frames (no FCS; the MAC inserts CRC) with a sequence-numbered, deterministic payload, honours tx_ready backpressure, and spaces frames by a programmable idle gap. It runs in the MAC 156.25 MHz domain.

Parameters:
DATA_W, 64, Avalon-ST data width in bits (8 bytes/beat)
EMPTY_W, 3, width of tx_empty
MIN_LEN, 60, minimum frame length in bytes, excluding FCS
MAX_LEN, 1514, maximum frame length in bytes, excluding FCS
ETHERTYPE, 16'h88B5, EtherType inserted at bytes 12-13

Ports:
clock156  input  1  MAC core clock, 156.25 MHz; all logic on rising edge
rst156  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; sampled only in IDLE
stop  input  1  level; ends the run after the current frame completes
cfg_pkt_count  input  32  frames per run; 0 = run continuously until stop
cfg_pkt_len  input  14  frame length in bytes, excluding FCS
cfg_ipg  input  8  idle cycles between frames
cfg_dst_mac  input  48  destination MAC address
cfg_src_mac  input  48  source MAC address
tx_ready  input  1  MAC ready; readyLatency 0
tx_valid  output  1  beat valid
tx_startofpacket  output  1  first beat of frame
tx_endofpacket  output  1  last beat of frame
tx_data  output  64  frame bytes; byte 0 on [63:56]
tx_empty  output  3  unused bytes in the last beat
tx_error  output  1  tied 0
busy  output  1  high while not IDLE
done  output  1  one-cycle pulse when a run ends
sent_count  output  32  frames fully accepted in the current run

Behaviour:
- Reset: FSM=IDLE. tx_valid, tx_startofpacket, tx_endofpacket, busy and done = 0. tx_data=0, tx_empty=0, sent_count=0. Sequence counter=0.
- Config latch: when start is seen in IDLE, the generator registers all cfg_* inputs. It clamps the length to [MIN_LEN, MAX_LEN]. It clears sent_count and the sequence counter and enters SEND. cfg_* changes during a run have no effect.
- Beat math: beats = ceil(L/8). byte_off = beat_idx*8. tx_empty = (8 - L%8)%8 on the last beat and 0 on all other beats.
- Frame bytes at offset k:
  - k 0-5: dst MAC, MSB first.
  - k 6-11: src MAC, MSB first.
  - k 12-13: ETHERTYPE.
  - k 14-17: sequence number, big-endian.
  - k >= 18: k[7:0].
  - Bytes past L in the last beat are 0.
- Handshake:
  - A beat transfers when tx_valid && tx_ready.
  - While tx_valid=1 and tx_ready=0, tx_data, tx_empty, sop and eop stay stable.
  - tx_valid never deasserts mid-frame. No bubbles are inserted inside a frame; tx_ready low just stalls.
  - The first beat is presented on the cycle after entering SEND (registered outputs).
- FSM:
  - IDLE -> SEND on start.
  - SEND -> (end check) when the eop beat is accepted:
    - On that cycle sent_count++ and the sequence counter increments.
    - If stop=1, or cfg_pkt_count!=0 and the new sent_count==cfg_pkt_count: go to IDLE, pulse done for 1 cycle, drop busy.
    - Else if cfg_ipg==0: the next frame's sop is presented the next cycle (back-to-back).
    - Else: go to IPG.
  - IPG: stays exactly cfg_ipg cycles with tx_valid=0, then SEND. If stop is asserted in IPG, go to IDLE with a done pulse.
- stop during SEND is not acted on mid-frame; the frame always completes.
- start while busy is ignored. start and stop together in IDLE: start is ignored.
- Counters: sent_count and the sequence counter wrap modulo 2^32. Continuous mode has no terminal count.
- Reset mid-frame: outputs return to reset values the next cycle, with no eop. The downstream MAC is reset alongside.

Test Plan:
- Single frame: cfg_pkt_len=64, count=1, ipg=0, ready=1 -> 8 beats.
  - Beat0 = {dst[47:0], src[47:32]}. Beat1 = {src[31:0], 16'h88B5, 16'h0000}. Beat2 = {16'h0000, bytes 0x12..0x17}.
  - eop on beat 7 with empty=0. done pulses once and sent_count=1.
- Odd length: cfg_pkt_len=61 -> 8 beats, empty=3 on the last beat. Last beat = {0x38,0x39,0x3A,0x3B,0x3C,0,0,0}.
- Clamping: cfg_pkt_len=20 -> 60-byte frame, empty=4. cfg_pkt_len=2000 -> 1514 bytes (190 beats), empty=6.
- Backpressure: tx_ready toggles randomly (50%) over 3 frames of 100 bytes, ipg=5.
  - Data is stable while stalled and there are no valid gaps inside a frame.
  - There are exactly 5 valid-low cycles between eop acceptance and the next sop.
  - Sequence numbers are 0, 1, 2.
- Stop: count=0, stop asserted mid-frame 4 -> frame 4 completes, then IDLE. sent_count=4 and one done pulse.
- Reset: rst156 asserted on beat 3 of a frame -> next cycle tx_valid=0 and busy=0. A later start re-runs with sequence 0.
